// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are latched at issue; the result commits to HI/LO after a fixed latency.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        sgn_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q;

  // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
  logic [63:0] mul_a_d, mul_b_d, prod_d;
  assign mul_a_d = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b_d = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod_d  = mul_a_d * mul_b_d;

  // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  logic        neg_a_d, neg_b_d;
  logic [31:0] mag_a_d, mag_b_d, qmag_d, rmag_d, quot_d, rem_d;
  assign neg_a_d = sgn_q & a_q[31];
  assign neg_b_d = sgn_q & b_q[31];
  assign mag_a_d = neg_a_d ? (32'd0 - a_q) : a_q;
  assign mag_b_d = neg_b_d ? (32'd0 - b_q) : b_q;
  assign qmag_d  = mag_a_d / mag_b_d;
  assign rmag_d  = mag_a_d % mag_b_d;
  assign quot_d  = (neg_a_d ^ neg_b_d) ? (32'd0 - qmag_d) : qmag_d;
  assign rem_d   = neg_a_d ? (32'd0 - rmag_d) : rmag_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sgn_q   <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              3'd1, 3'd2: begin
                state_q <= MUL;
                cnt_q   <= 4'(MULT_CYCLES - 1);
                busy_q  <= 1'b1;
                sgn_q   <= (op == 3'd1);
                a_q     <= a;
                b_q     <= b;
              end
              3'd3, 3'd4: begin
                state_q <= DIV;
                cnt_q   <= 4'(DIV_CYCLES - 1);
                busy_q  <= 1'b1;
                sgn_q   <= (op == 3'd3);
                a_q     <= a;
                b_q     <= b;
              end
              3'd5:    hi_q <= a;
              3'd6:    lo_q <= a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt_q == 4'd0) begin
            hi_q    <= prod_d[63:32];
            lo_q    <= prod_d[31:0];
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DIV: begin
          if (cnt_q == 4'd0) begin
            // Divide by zero burns the full latency but leaves HI/LO untouched.
            if (b_q != 32'd0) begin
              hi_q <= rem_d;
              lo_q <= quot_d;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: a cycle model compared every cycle plus directed literal checks.
module tb_e_mdu;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit run = 0;

  e_mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result from plain 64-bit arithmetic: {hi, lo}.
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    logic [63:0] r;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    r = 64'd0;
    case (o)
      3'd1: r = sx * sy;
      3'd2: r = ux * uy;
      3'd3: if (y != 32'd0) r = {32'(sx % sy), 32'(sx / sy)};
      3'd4: if (y != 32'd0) r = {32'(ux % uy), 32'(ux / uy)};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Model: remaining busy cycles plus a pending result that lands when the count runs out.
  int          m_rem;
  logic        m_commit;
  logic [63:0] m_res;
  logic [31:0] m_hi, m_lo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rem    <= 0;
      m_commit <= 1'b0;
      m_res    <= 64'd0;
      m_hi     <= 32'd0;
      m_lo     <= 32'd0;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && m_commit) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
    end else if (start) begin
      case (op)
        3'd1, 3'd2: begin
          m_rem <= MULT_CYCLES; m_res <= model_result(op, a, b); m_commit <= 1'b1;
        end
        3'd3, 3'd4: begin
          m_rem <= DIV_CYCLES; m_res <= model_result(op, a, b); m_commit <= (b != 32'd0);
        end
        3'd5: m_hi <= a;
        3'd6: m_lo <= a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (run) begin
      checks += 3;
      if (busy !== (m_rem != 0)) begin
        errors++;
        $display("FAIL cyc_busy actual=%b required=%b t=%0t", busy, (m_rem != 0), $time);
      end
      if (hi !== m_hi) begin
        errors++;
        $display("FAIL cyc_hi actual=%h required=%h t=%0t", hi, m_hi, $time);
      end
      if (lo !== m_lo) begin
        errors++;
        $display("FAIL cyc_lo actual=%h required=%h t=%0t", lo, m_lo, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    $display("txn op=%0d a=%h b=%h -> busy=%b hi=%h lo=%h", o, x, y, busy, hi, lo);
    start = 1'b0; op = 3'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  int n;

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    run = 1;
    @(negedge clk);

    // Reset mid-operation abandons the MULT.
    issue(3'd5, 32'h55, 32'd0);
    issue(3'd1, 32'd3, 32'd4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_nocommit_hi", hi, 32'd0);
    chk("midrst_nocommit_lo", lo, 32'd0);

    // MULT / MULTU of -2 * 3.
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    chk("mult_busy_len", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    chk("model_mult_lo", m_lo, 32'hFFFFFFFA);
    issue(3'd2, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    chk("multu_busy_len", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);
    chk("model_multu_hi", m_hi, 32'h00000002);

    // DIV -7 / 2 and DIVU 7 / 2.
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div_busy_len", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("model_div_hi", m_hi, 32'hFFFFFFFF);
    issue(3'd4, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // Divide by zero leaves preloaded HI/LO alone.
    issue(3'd5, 32'h11, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    chk("mthi_hi", hi, 32'h11);
    chk("mtlo_lo", lo, 32'h22);
    issue(3'd3, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_busy_len", 32'(n), 32'd10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    // Overflow divide, then back-to-back MULTU on the first idle cycle.
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("ovf_busy_len", 32'(n), 32'd10);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'd0);
    chk("model_ovf_lo", m_lo, 32'h80000000);
    issue(3'd2, 32'h10000, 32'h10000);
    chk("b2b_accept", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("b2b_busy_len", 32'(n), 32'd5);
    chk("b2b_hi", hi, 32'd1);
    chk("b2b_lo", lo, 32'd0);

    // Starts while busy are ignored.
    issue(3'd1, 32'd3, 32'd4);
    issue(3'd6, 32'hDEAD, 32'd0);
    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    chk("ign_busy_rest", 32'(n), 32'd3);
    chk("ign_lo", lo, 32'd12);
    chk("ign_hi", hi, 32'd0);
    repeat (12) @(negedge clk);
    chk("ign_no_div", {31'd0, busy}, 32'd0);
    chk("ign_lo_final", lo, 32'd12);

    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers. Sits in the E stage beside the ALU.
- Accepts one operation per start pulse and latches the operands. Counts a fixed latency, then commits the result to HI/LO.
- Exports busy to the stall unit, which holds D-stage mult/div/mfhi/mflo/mthi/mtlo instructions while busy or start is high.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (1..15)
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (1..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately)
- start  in  1  issue strobe from E-stage control, one cycle per instruction
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
- a  in  32  forwarded rs value (fw_E_rs_d)
- b  in  32  forwarded rt value (fw_E_rt_d)
- busy  out  1  registered; high while a mult/div is in flight
- hi  out  32  HI register, read by mfhi via E-stage mux
- lo  out  32  LO register, read by mflo via E-stage mux

Behaviour:
- Reset (reset==0, async): hi=0, lo=0, busy=0, counter=0, state=IDLE, latched operands=0. Reset mid-operation abandons the operation; no commit.
- FSM states: IDLE, MUL, DIV.
- Issue rule: start==1 && busy==0 at a rising edge samples op, a, b.
  - MULT/MULTU: go to MUL; counter=MULT_CYCLES-1; busy=1 from the next cycle.
  - DIV/DIVU: go to DIV; counter=DIV_CYCLES-1; busy=1 from the next cycle.
  - MTHI: hi<=a on the same edge; busy stays 0; state stays IDLE. MTLO: lo<=a likewise.
  - NOP/7: no effect.
- start==1 while busy==1 is ignored entirely: no operand latch, no HI/LO write. The stall unit must prevent this; the bench checks that it is ignored.
- In MUL/DIV, the counter decrements every cycle. At the edge where counter==0: hi/lo <= result, busy<=0, state<=IDLE.
  - busy is therefore high for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - A new start is accepted on the first cycle busy==0 (back-to-back issue, no bubble).
- hi/lo hold their old values for the whole busy window. The result is never visible early.
- Arithmetic (operands are the values latched at issue; a and b changes during busy are ignored):
  - MULT: {hi,lo} = signed(a)*signed(b), 64-bit.
  - MULTU: {hi,lo} = unsigned product, 64-bit.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: lo = a/b, hi = a%b, unsigned.
  - DIV with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b==0, DIV or DIVU): full latency with busy asserted; at commit hi/lo stay unchanged.
- The result may be computed combinationally from the latched operands and registered at commit. An iterative datapath is also permitted. The only requirement is cycle-exact busy timing and the commit edge.

Test Plan:
- Reset mid-operation: issue MULT a=3 b=4, drop reset low at cycle 2 -> busy=0, hi=0, lo=0 immediately; no later commit.
- MULT a=0xFFFFFFFE(-2), b=3 -> busy high exactly 5 cycles; hi/lo unchanged while busy; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- Divide by zero: preload MTHI 0x11, MTLO 0x22, then DIV a=5 b=0 -> busy 10 cycles; hi=0x11, lo=0x22 after.
- Overflow and back-to-back: DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. On the cycle busy falls, issue MULTU 0x10000*0x10000 -> accepted immediately; hi=1, lo=0 five cycles later.
- Start while busy: during MULT, pulse start with MTLO a=0xDEAD and with DIV -> both ignored; lo equals the MULT result; busy drops on schedule.
